// File: rtl/tx_sched_gate.sv
// Transmit scheduling gate: pops one TX header, holds its timestamp against the
// external time comparator, then releases (tx_start) or discards (tx_drop) the packet.
module tx_sched_gate #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                hdr_valid,
  input  logic [BITS-1:0]     hdr_timestamp,
  output logic                hdr_ack,
  output logic [BITS-1:0]     cmp_timestamp,
  input  logic                cmp_match,
  input  logic                cmp_valid,
  output logic                tx_start,
  output logic                tx_drop,
  input  logic                tx_done,
  output logic                busy,
  output logic [CNT_BITS-1:0] late_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, BUSY} state_t;

  localparam logic [BITS-1:0]     NOW     = '1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [BITS-1:0]     ts_q, ts_d;
  logic                ack_q, ack_d;
  logic                start_q, start_d;
  logic                drop_q, drop_d;
  logic                busy_q, busy_d;
  logic [CNT_BITS-1:0] late_q, late_d;

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    ack_d   = 1'b0;
    start_d = 1'b0;
    drop_d  = 1'b0;
    late_d  = late_q;
    unique case (state_q)
      IDLE: begin
        if (enable && hdr_valid) begin
          ts_d    = hdr_timestamp;
          ack_d   = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: state_d = WAIT;
      WAIT: begin
        // NOW bypasses the comparator, so it must be checked before cmp_valid.
        if (ts_q == NOW) begin
          start_d = 1'b1;
          state_d = BUSY;
        end else if (!cmp_valid) begin
          drop_d  = 1'b1;
          state_d = BUSY;
          if (late_q != CNT_MAX) late_d = late_q + CNT_BITS'(1);
        end else if (cmp_match) begin
          start_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ts_q    <= '0;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
      late_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
      late_q  <= late_d;
    end
  end

  assign hdr_ack       = ack_q;
  assign cmp_timestamp = ts_q;
  assign tx_start      = start_q;
  assign tx_drop       = drop_q;
  assign busy          = busy_q;
  assign late_count    = late_q;

endmodule
